// File: rtl/regbank_wport_arbiter_if.sv
// ---------------------------------------------------------------------------
// regbank_wport_arbiter_if
//   Bundles the two writeback requester handshakes, the stall input and the
//   register-bank write port into one interface.
//
//   slave  modport : used by the arbiter (requests/stall in, readies/bank out)
//   master modport : used by whatever drives the requesters and observes
//                    the bank side (the testbench)
//
//   Signals:
//     stall           - suppress all grants this cycle
//     reqN_valid      - requester N has a write pending
//     reqN_addr/data  - requester N destination register / write data
//     reqN_ready      - requester N write accepted this cycle
//     we3/wa3/wd3     - registered write strobe/address/data to the bank
//     wr15_err        - pulse when a write to R15 was dropped
//     contention_cnt  - saturating count of cycles with both requesters valid
// ---------------------------------------------------------------------------
interface regbank_wport_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 32,
  parameter int CW = 8
);
  logic          stall;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic          wr15_err;
  logic [CW-1:0] contention_cnt;

  modport slave (
    input  stall,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output we3, wa3, wd3, wr15_err, contention_cnt
  );

  modport master (
    output stall,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  we3, wa3, wd3, wr15_err, contention_cnt
  );
endinterface

// File: rtl/regbank_wport_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_wport_arbiter
//   Shares the register bank's single write port between requester 0 (ALU
//   result) and requester 1 (memory load data). Arbitration is round-robin
//   with a valid/ready handshake; the winning write is registered so the bank
//   sees a clean one-cycle strobe. Writes to R15 (the PC, supplied to the bank
//   separately) are accepted but dropped and flagged on wr15_err. A saturating
//   counter records cycles in which both requesters were valid.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-high reset
//     bus    - regbank_wport_arbiter_if.slave (requests, stall, bank port)
// ---------------------------------------------------------------------------
module regbank_wport_arbiter #(
  parameter int AW = 4,
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  regbank_wport_arbiter_if.slave   bus
);

  logic          last_grant_q, last_grant_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic          wr15_err_q, wr15_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ready0, ready1;
  logic          xfer0, xfer1, xfer;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selData;
  logic          isR15;
  logic          bothValid;

  // Grant selection: when both requesters compete, the one that was not
  // granted last wins; a lone requester always wins; stall blocks everything.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (!bus.stall) begin
      if (bus.req0_valid && bus.req1_valid) begin
        ready0 = last_grant_q;
        ready1 = !last_grant_q;
      end else if (bus.req0_valid) begin
        ready0 = 1'b1;
      end else if (bus.req1_valid) begin
        ready1 = 1'b1;
      end
    end
  end

  assign xfer0     = ready0 && bus.req0_valid;
  assign xfer1     = ready1 && bus.req1_valid;
  assign xfer      = xfer0 || xfer1;
  assign selAddr   = xfer1 ? bus.req1_addr : bus.req0_addr;
  assign selData   = xfer1 ? bus.req1_data : bus.req0_data;
  assign isR15     = (selAddr == {AW{1'b1}});
  assign bothValid = bus.req0_valid && bus.req1_valid;

  // Next-state for the registered write port. A dropped R15 write leaves
  // wa3/wd3 holding the last real write so the bank never sees R15 on wa3.
  // The grant pointer moves on every completed handshake, dropped or not.
  // Contention counts even while stalled and sticks at all-ones.
  always_comb begin
    we3_d        = xfer && !isR15;
    wr15_err_d   = xfer && isR15;
    wa3_d        = wa3_q;
    wd3_d        = wd3_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if (xfer && !isR15) begin
      wa3_d = selAddr;
      wd3_d = selData;
    end
    if (xfer) begin
      last_grant_d = xfer1;
    end
    if (bothValid && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers. Reset cancels any in-flight write immediately and
  // points last_grant at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      we3_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
      wr15_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we3_q        <= we3_d;
      wa3_q        <= wa3_d;
      wd3_q        <= wd3_d;
      wr15_err_q   <= wr15_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req0_ready     = ready0;
  assign bus.req1_ready     = ready1;
  assign bus.we3            = we3_q;
  assign bus.wa3            = wa3_q;
  assign bus.wd3            = wd3_q;
  assign bus.wr15_err       = wr15_err_q;
  assign bus.contention_cnt = cnt_q;

endmodule
